accum_ctrl: RTL and testbench

Sequencing controller for the lab's 17-bit accumulate datapath. It turns the Run_Accumulate pushbutton level into exactly one add per press, presents operands to an external multi-cycle adder (ripple, lookahead or select), waits that adder's fixed latency, captures the sum into the accumulator register, and tracks the operation count and overflow. It sits between the switch/button inputs and the adder instance. Its Out drives the hex display path.

---
 rtl/accum_ctrl.sv | 121 ++++++++++++
 tb/tb_accum_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_ctrl.sv
// rtl/accum_ctrl.sv - one-add-per-press accumulate sequencer around an external multi-cycle adder
// Optional saturation on carry-out: define ACCUM_SAT_EN.
module accum_ctrl #(
  parameter int ADDER_LAT   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Reset_Clear,
  input  logic        Run_Accumulate,
  input  logic [9:0]  SW,
  input  logic [16:0] Adder_S,
  input  logic        Adder_Cout,
  output logic [16:0] Adder_A,
  output logic [16:0] Adder_B,
  output logic [16:0] Out,
  output logic        Busy,
  output logic        Done,
  output logic        Overflow,
  output logic [7:0]  Op_Count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  localparam logic [3:0] LAT = 4'(ADDER_LAT);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   run_s, run_q, rise;
  logic                   latch_op, capture;
  logic [9:0]             op_q;
  logic [3:0]             wait_cnt;
  logic [16:0]            acc_q;
  logic                   done_q, ovf_q;
  logic [7:0]             op_cnt_q;

  assign run_s = sync_q[SYNC_STAGES-1];
  assign rise  = run_s & ~run_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
      run_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Run_Accumulate};
      run_q  <= run_s;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    latch_op = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: if (rise) begin
        latch_op = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: if (wait_cnt == 4'd1) begin
        capture = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: if (!run_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Clear aborts any operation and parks in HOLD so a held button cannot retrigger.
    if (Reset_Clear) begin
      state_d  = S_HOLD;
      latch_op = 1'b0;
      capture  = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q     <= '0;
      wait_cnt <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      done_q <= capture;
      if (latch_op) begin
        op_q     <= SW;
        wait_cnt <= LAT;
      end else if (Reset_Clear) begin
        wait_cnt <= '0;
      end else if (state_q == S_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (Reset_Clear) begin
        acc_q    <= '0;
        ovf_q    <= 1'b0;
        op_cnt_q <= '0;
      end else if (capture) begin
`ifdef ACCUM_SAT_EN
        acc_q <= Adder_Cout ? 17'h1FFFF : Adder_S;
`else
        acc_q <= Adder_S;
`endif
        ovf_q    <= ovf_q | Adder_Cout;
        op_cnt_q <= op_cnt_q + 8'd1;
      end
    end
  end

  assign Out      = acc_q;
  assign Adder_A  = acc_q;
  assign Adder_B  = {7'b0, op_q};
  assign Busy     = (state_q == S_WAIT);
  assign Done     = done_q;
  assign Overflow = ovf_q;
  assign Op_Count = op_cnt_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// tb/tb_accum_ctrl.sv - randomized self-checking bench for accum_ctrl (ADDER_LAT=1 and ADDER_LAT=4 instances)
module tb_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        run = 1'b0;
  logic [9:0]  sw  = '0;

  logic [16:0] a1, b1, s1, out1, a4, b4, s4, out4;
  logic        c1, busy1, done1, ovf1, c4, busy4, done4, ovf4;
  logic [7:0]  op1, op4;
  logic [17:0] sum1, sum4;

  int n_checks = 0;
  int n_pass   = 0;
  int dc1 = 0;
  int dc4 = 0;

  logic [16:0] m_out;
  logic [7:0]  m_cnt;
  logic        m_ovf;

  always #5 clk = ~clk;

  // Ideal external adders: the DUT only samples them on its capture edge.
  assign sum1 = {1'b0, a1} + {1'b0, b1};
  assign s1   = sum1[16:0];
  assign c1   = sum1[17];
  assign sum4 = {1'b0, a4} + {1'b0, b4};
  assign s4   = sum4[16:0];
  assign c4   = sum4[17];

  accum_ctrl u_dut1 (
    .Clk(clk), .Reset(rst), .Reset_Clear(clr), .Run_Accumulate(run), .SW(sw),
    .Adder_S(s1), .Adder_Cout(c1), .Adder_A(a1), .Adder_B(b1), .Out(out1),
    .Busy(busy1), .Done(done1), .Overflow(ovf1), .Op_Count(op1)
  );

  accum_ctrl #(.ADDER_LAT(4)) u_dut4 (
    .Clk(clk), .Reset(rst), .Reset_Clear(clr), .Run_Accumulate(run), .SW(sw),
    .Adder_S(s4), .Adder_Cout(c4), .Adder_A(a4), .Adder_B(b4), .Out(out4),
    .Busy(busy4), .Done(done4), .Overflow(ovf4), .Op_Count(op4)
  );

  always @(negedge clk) begin
    if (done1) dc1++;
    if (done4) dc4++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_out = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_add(input logic [9:0] v);
    int unsigned s;
    s = int'(m_out) + int'(v);
    if (s > 32'h1FFFF) begin
      m_ovf = 1'b1;
`ifdef ACCUM_SAT_EN
      m_out = 17'h1FFFF;
`else
      m_out = 17'(s - 32'h20000);
`endif
    end else begin
      m_out = 17'(s);
    end
    m_cnt = m_cnt + 8'd1;
  endtask

  task automatic press(input logic [9:0] v, input int hold, input int rel);
    sw  = v;
    run = 1'b1;
    repeat (hold) tick();
    run = 1'b0;
    repeat (rel) tick();
    model_add(v);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (6) tick();
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (out1 !== 17'd0) $display("FAIL reset_out1: got %h exp 0", out1); else n_pass++;
    n_checks++; if (out4 !== 17'd0) $display("FAIL reset_out4: got %h exp 0", out4); else n_pass++;
    n_checks++; if (b1 !== 17'd0) $display("FAIL reset_b1: got %h exp 0", b1); else n_pass++;
    n_checks++; if ({busy1, done1, ovf1} !== 3'b000) $display("FAIL reset_flags1: got %b exp 000", {busy1, done1, ovf1}); else n_pass++;
    n_checks++; if (op4 !== 8'd0) $display("FAIL reset_op4: got %0d exp 0", op4); else n_pass++;
    rst = 1'b0;
    tick();
    model_clear();
  endtask

  task automatic test_basic_add();
    sw  = 10'd7;
    run = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      tick();
      if (e == 2) begin
        n_checks++; if (busy1 !== 1'b1) $display("FAIL basic_busy: got %b exp 1", busy1); else n_pass++;
        n_checks++; if (out1 !== 17'd0) $display("FAIL basic_early_out: got %h exp 0", out1); else n_pass++;
      end
      if (e == 3) begin
        n_checks++; if (out1 !== 17'd7) $display("FAIL basic_out: got %h exp 7", out1); else n_pass++;
        n_checks++; if (done1 !== 1'b1) $display("FAIL basic_done: got %b exp 1", done1); else n_pass++;
        n_checks++; if (op1 !== 8'd1) $display("FAIL basic_opcnt: got %0d exp 1", op1); else n_pass++;
        n_checks++; if (a1 !== out1) $display("FAIL basic_adder_a: got %h exp %h", a1, out1); else n_pass++;
        run = 1'b0;
      end
      if (e == 4) begin
        n_checks++; if (done1 !== 1'b0) $display("FAIL basic_done_width: got %b exp 0", done1); else n_pass++;
      end
    end
    repeat (8) tick();
    model_add(10'd7);
    n_checks++; if (out4 !== m_out) $display("FAIL basic_out4: got %h exp %h", out4, m_out); else n_pass++;
    press(10'd11, 8, 6);
    n_checks++; if (out1 !== 17'h00012) $display("FAIL basic_second: got %h exp 00012", out1); else n_pass++;
    n_checks++; if (op1 !== 8'd2) $display("FAIL basic_opcnt2: got %0d exp 2", op1); else n_pass++;
    n_checks++; if (out4 !== m_out) $display("FAIL basic_second4: got %h exp %h", out4, m_out); else n_pass++;
  endtask

  task automatic test_latency();
    int busy_n;
    do_clear();
    busy_n = 0;
    sw  = 10'd3;
    run = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      if (busy4) busy_n++;
      if (e == 3) sw = 10'h3FF;
      if (e == 5) begin
        n_checks++; if (out4 !== 17'd0) $display("FAIL lat_early_out: got %h exp 0", out4); else n_pass++;
        n_checks++; if (b4 !== 17'd3) $display("FAIL lat_operand_b: got %h exp 3", b4); else n_pass++;
      end
      if (e == 6) begin
        n_checks++; if (out4 !== 17'd3) $display("FAIL lat_out: got %h exp 3", out4); else n_pass++;
        n_checks++; if ({busy4, done4} !== 2'b01) $display("FAIL lat_busy_done: got %b exp 01", {busy4, done4}); else n_pass++;
      end
    end
    n_checks++; if (busy_n != 4) $display("FAIL lat_busy_cycles: got %0d exp 4", busy_n); else n_pass++;
    run = 1'b0;
    repeat (8) tick();
    model_add(10'd3);
    n_checks++; if (out1 !== m_out) $display("FAIL lat_out1: got %h exp %h", out1, m_out); else n_pass++;
  endtask

  task automatic test_clear_mid_op();
    int d4;
    do_clear();
    press(10'd7, 8, 6);
    press(10'd11, 8, 6);
    n_checks++; if (out4 !== 17'd18) $display("FAIL clr_setup: got %h exp 00012", out4); else n_pass++;
    sw  = 10'd5;
    run = 1'b1;
    repeat (4) tick();
    clr = 1'b1;
    d4  = dc4;
    tick();
    clr = 1'b0;
    n_checks++; if (out4 !== 17'd0) $display("FAIL clr_out4: got %h exp 0", out4); else n_pass++;
    n_checks++; if ({op4, busy4} !== 9'd0) $display("FAIL clr_op_busy4: got %h exp 0", {op4, busy4}); else n_pass++;
    repeat (12) tick();
    n_checks++; if (dc4 != d4) $display("FAIL clr_no_done: got %0d exp %0d", dc4, d4); else n_pass++;
    n_checks++; if ({out1, busy1} !== 18'd0) $display("FAIL clr_no_retrigger: got %h exp 0", {out1, busy1}); else n_pass++;
    model_clear();
    run = 1'b0;
    repeat (6) tick();
    press(10'd9, 8, 6);
    n_checks++; if (out4 !== 17'd9 || op4 !== 8'd1) $display("FAIL clr_repress: got %h/%0d exp 9/1", out4, op4); else n_pass++;
  endtask

  task automatic test_async_reset();
    sw  = 10'd4;
    run = 1'b1;
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({out1, out4} !== 34'd0) $display("FAIL arst_out: got %h/%h exp 0", out1, out4); else n_pass++;
    n_checks++; if ({busy4, done1, ovf1} !== 3'b000) $display("FAIL arst_flags: got %b exp 000", {busy4, done1, ovf1}); else n_pass++;
    n_checks++; if ({b4, op1} !== 25'd0) $display("FAIL arst_b_op: got %h exp 0", {b4, op1}); else n_pass++;
    run = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    model_clear();
    press(10'd2, 8, 6);
    n_checks++; if (out1 !== 17'd2 || out4 !== 17'd2) $display("FAIL arst_repress: got %h/%h exp 2", out1, out4); else n_pass++;
  endtask

  task automatic test_held_button();
    int d1, d4;
    do_clear();
    d1 = dc1;
    d4 = dc4;
    press(10'd5, 40, 6);
    n_checks++; if (dc1 - d1 != 1) $display("FAIL held_done1: got %0d exp 1", dc1 - d1); else n_pass++;
    n_checks++; if (dc4 - d4 != 1) $display("FAIL held_done4: got %0d exp 1", dc4 - d4); else n_pass++;
    n_checks++; if (out1 !== 17'd5) $display("FAIL held_out: got %h exp 5", out1); else n_pass++;
    press(10'd5, 8, 6);
    n_checks++; if (out4 !== 17'd10) $display("FAIL held_again: got %h exp 0000a", out4); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [16:0] exp_out;
`ifdef ACCUM_SAT_EN
    exp_out = 17'h1FFFF;
`else
    exp_out = 17'h0037F;
`endif
    do_clear();
    for (int i = 0; i < 129; i++) press(10'h3FF, 8, 6);
    n_checks++; if (out1 !== exp_out) $display("FAIL ovf_out1: got %h exp %h", out1, exp_out); else n_pass++;
    n_checks++; if (out4 !== m_out) $display("FAIL ovf_out4: got %h exp %h", out4, m_out); else n_pass++;
    n_checks++; if ({ovf1, ovf4} !== 2'b11) $display("FAIL ovf_flag: got %b exp 11", {ovf1, ovf4}); else n_pass++;
    n_checks++; if (op1 !== 8'd129) $display("FAIL ovf_opcnt: got %0d exp 129", op1); else n_pass++;
  endtask

  task automatic test_random();
    int d1, d4;
    logic [9:0] v;
    for (int i = 0; i < 140; i++) begin
      v  = 10'($urandom_range(0, 1023));
      d1 = dc1;
      d4 = dc4;
      press(v, int'($urandom_range(8, 20)), int'($urandom_range(6, 10)));
      n_checks++; if (out1 !== m_out || out4 !== m_out) $display("FAIL rand_out[%0d]: got %h/%h exp %h", i, out1, out4, m_out); else n_pass++;
      n_checks++; if (op1 !== m_cnt || op4 !== m_cnt) $display("FAIL rand_opcnt[%0d]: got %0d/%0d exp %0d", i, op1, op4, m_cnt); else n_pass++;
      n_checks++; if (ovf1 !== m_ovf || ovf4 !== m_ovf) $display("FAIL rand_ovf[%0d]: got %b/%b exp %b", i, ovf1, ovf4, m_ovf); else n_pass++;
      n_checks++; if (dc1 - d1 != 1 || dc4 - d4 != 1) $display("FAIL rand_done[%0d]: got %0d/%0d exp 1", i, dc1 - d1, dc4 - d4); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_latency();
    test_clear_mid_op();
    test_async_reset();
    test_held_button();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
